regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, write port, clear request, debug tap and busy.
// The master side drives addresses, write data and requests. The slave side
// (the register file) returns the read data and the busy flag.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] Din;
  logic              we;
  logic              clr;
  logic [ADDR_W-1:0] dbgReg;
  logic [DATA_W-1:0] dbg;
  logic              busy;

  modport master (
    output readReg1, readReg2, writeReg, Din, we, clr, dbgReg,
    input  reg1, reg2, dbg, busy
  );

  modport slave (
    input  readReg1, readReg2, writeReg, Din, we, clr, dbgReg,
    output reg1, reg2, dbg, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing sweep after reset or on request.
// Two combinational read ports, one combinational debug read port, and one
// synchronous write port. Register 0 can be hardwired to zero (ZERO_REG).
// Optional feature: define REGFILE_BYPASS_EN for write-first read behaviour
// (a read that hits the address being written returns Din in the same cycle).
// Without it, reads are read-first and show the new value one cycle later.
//
// state  | meaning
// CLEAR  | sweeping zeros into register[cnt]; all reads forced to 0, writes dropped
// READY  | normal operation; writes accepted, clr starts a new sweep
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic busy;
  logic wr_drop;
  logic wr_en;

  assign busy    = (state_q == S_CLEAR);
  // Writes to register 0 are dropped when it is hardwired to zero.
  assign wr_drop = (ZERO_REG != 0) && (bus.writeReg == '0);
  // clr takes priority over we, and nothing is written while in reset.
  assign wr_en   = !busy && !rst && bus.we && !bus.clr && !wr_drop;

  assign bus.busy = busy;

  // Next-state and sweep counter. The counter holds at its last value so the sweep runs only once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bus.clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State register. Reset restarts the sweep from address 0 from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage. The sweep zeroes one entry per cycle; otherwise accept the write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[bus.writeReg] <= bus.Din;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              blocked,
    input logic              wr_hit_en,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS && wr_hit_en && (addr == waddr)) begin
      v = wdata;
    end
    if (blocked || ((ZERO_REG != 0) && (addr == '0))) begin
      v = '0;
    end
    return v;
  endfunction

  // Read ports share the same masking: zero while sweeping and for hardwired register 0.
  always_comb begin
    bus.reg1 = rd_sel(bus.readReg1, mem_q[bus.readReg1], busy, wr_en, bus.writeReg, bus.Din);
    bus.reg2 = rd_sel(bus.readReg2, mem_q[bus.readReg2], busy, wr_en, bus.writeReg, bus.Din);
    bus.dbg  = rd_sel(bus.dbgReg,   mem_q[bus.dbgReg],   busy, wr_en, bus.writeReg, bus.Din);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp. Two instances (ZERO_REG = 1 and 0)
// share one stimulus stream. A reference model predicts each cycle's outputs.
// The predictions are queued, and a negedge monitor compares them against the DUT.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          we, clr;
  logic [AW-1:0] wa, ra1, ra2, rdbg;
  logic [DW-1:0] din;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.readReg1 = ra1;  assign bus1.readReg1 = ra1;
  assign bus0.readReg2 = ra2;  assign bus1.readReg2 = ra2;
  assign bus0.dbgReg   = rdbg; assign bus1.dbgReg   = rdbg;
  assign bus0.writeReg = wa;   assign bus1.writeReg = wa;
  assign bus0.Din      = din;  assign bus1.Din      = din;
  assign bus0.we       = we;   assign bus1.we       = we;
  assign bus0.clr      = clr;  assign bus1.clr      = clr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model [2][DEPTH];
  int          busy_left;

  function automatic void model_clear();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) model[i][j] = '0;
  endfunction

  // Expected read data given the model and the inputs currently applied.
  function automatic logic [31:0] exp_rd(int inst, logic [AW-1:0] a);
    if (busy_left > 0) return '0;
    if (inst == 0 && a == 0) return '0;
    if (BYP && !rst && we && !clr && a == wa && !(inst == 0 && wa == 0)) return din;
    return model[inst][a];
  endfunction

  function automatic logic [31:0] actual(int inst, int port);
    logic [31:0] v;
    v = '0;
    case ({inst[0], port[1:0]})
      3'b000: v = bus0.reg1;
      3'b001: v = bus0.reg2;
      3'b010: v = bus0.dbg;
      3'b011: v = {31'd0, bus0.busy};
      3'b100: v = bus1.reg1;
      3'b101: v = bus1.reg2;
      3'b110: v = bus1.dbg;
      default: v = {31'd0, bus1.busy};
    endcase
    return v;
  endfunction

  function automatic void push(int inst, int port, logic [31:0] e, string nm);
    chk_t c;
    c.inst = inst; c.port = port; c.exp = e; c.name = nm;
    q.push_back(c);
  endfunction

  task automatic chk_direct(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: check every prediction queued since the previous falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        e;
      logic [31:0] act;
      e   = q.pop_front();
      act = actual(e.inst, e.port);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s inst%0d port%0d: got %h expected %h at %0t",
                 e.name, e.inst, e.port, act, e.exp, $time);
      end
    end
  end

  // One clock cycle: apply inputs, queue predictions, then advance the model at the edge.
  task automatic cyc(input bit r, input bit w, input bit c, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [AW-1:0] p1,
                     input logic [AW-1:0] p2, input logic [AW-1:0] pd, input string tag);
    rst = r; we = w; clr = c; wa = a; din = d; ra1 = p1; ra2 = p2; rdbg = pd;
    for (int i = 0; i < 2; i++) begin
      push(i, 0, exp_rd(i, p1), {tag, ".reg1"});
      push(i, 1, exp_rd(i, p2), {tag, ".reg2"});
      push(i, 2, exp_rd(i, pd), {tag, ".dbg"});
      push(i, 3, (busy_left > 0) ? 32'd1 : 32'd0, {tag, ".busy"});
    end
    @(posedge clk);
    if (r) begin
      busy_left = DEPTH;
      model_clear();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (c) begin
      busy_left = DEPTH;
      model_clear();
    end else if (w) begin
      model[1][a] = d;
      if (a != 0) model[0][a] = d;
    end
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, AW'($urandom), $urandom,
          AW'($urandom), AW'($urandom), AW'($urandom), tag);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b0, 1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), AW'(i), tag);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; clr = 1'b0; wa = '0; din = '0; ra1 = '0; ra2 = '0; rdbg = '0;
    @(posedge clk);
    #1;
    busy_left = DEPTH;
    model_clear();

    ra1 = 5'd3; ra2 = 5'd7; rdbg = 5'd1;
    #1;
    chk_direct({bus1.reg1 | bus1.reg2 | bus1.dbg | bus0.reg1 | bus0.reg2 | bus0.dbg},
               32'h0, "reset_state.data");
    chk_direct({30'd0, bus1.busy, bus0.busy}, 32'h3, "reset_state.busy");

    // Sweep after a one-cycle reset; write attempts during the sweep must be dropped.
    idle(DEPTH, "rst_sweep");
    chk_direct({30'd0, bus1.busy, bus0.busy}, 32'h0, "sweep_expired.busy");
    read_all("post_rst");

    // Basic writes and read-back on reg1 and the debug port.
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 32'hDEADBEEF, 5'd2, 5'd4, 5'd4, "wr2");
    cyc(1'b0, 1'b1, 1'b0, 5'd4, 32'h12345678, 5'd2, 5'd4, 5'd4, "wr4");
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd4, 5'd4, "rd24");

    // Register 0 handling for both ZERO_REG builds.
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, "wr0");
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd2, 5'd0, "rd0");

    // Same-cycle read and write of one address: write-first or read-first.
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 32'h1, 5'd5, 5'd5, 5'd5, "wr5a");
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 32'hAA, 5'd5, 5'd4, 5'd5, "byp5");
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, "rd5");

    // clr and we together: the sweep wins, the write is dropped.
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 32'h55, 5'd7, 5'd2, 5'd7, "clr_we");
    idle(DEPTH, "clr_sweep");
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd2, 5'd4, "rd7");

    // Randomised traffic with occasional clr and rst, biased to hit the bypass path.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      cyc(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 59) == 0), a, $urandom,
          ($urandom_range(0, 1) != 0) ? a : AW'($urandom), AW'($urandom),
          ($urandom_range(0, 2) == 0) ? a : AW'($urandom), "rand");
    end
    idle(DEPTH + 1, "settle");

    // Fill some registers, then reset at sweep cycle 10 of a clr sweep.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b1, 1'b0, AW'(i), $urandom | 32'h1, AW'(i), '0, '0, "fill");
    cyc(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0, "clr2");
    idle(10, "sweep10");
    cyc(1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFE, 5'd9, 5'd1, 5'd3, "mid_rst");
    idle(DEPTH, "rst2_sweep");
    read_all("post_rst2");

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
